lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the single-cycle ALU: it takes the ALU `result` as the effective address plus `rs2` store data, and runs one data-memory transaction per request. It aligns and strobes store data, extracts and sign- or zero-extends load data, and flags misaligned or illegal accesses without touching memory. A valid/ready handshake runs toward memory, and `stall` is held to the core while the unit is busy.

## Interface
- `AW`, 32, address width; `mem_addr` is word-aligned, so bits [1:0] are always 0.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core presents a memory op this cycle.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  AW  effective address (ALU result).
- `req_wdata`  in  32  store data (rs2).
- `mem_valid`  out  1  transaction request to data memory.
- `mem_ready`  in  1  memory accepts/completes the transaction this cycle.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  AW  word address: `{addr[AW-1:2],2'b00}`.
- `mem_wstrb`  out  4  byte-lane write strobes.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read word; valid in the cycle `mem_ready` is high on a load.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  2  [0] misaligned, [1] illegal funct3.
- `stall`  out  1  equals `~req_ready`.

## Operation
- FSM states: IDLE, MEM, RESP. Reset forces IDLE asynchronously.
- Values after reset:
  - `req_ready`=1, `stall`=0.
  - `mem_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wstrb`=0, `mem_wdata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0.
- IDLE, accepting a request (`req_valid`&`req_ready` at a clock edge):
  - Latch `we`, `funct3`, `addr` and `wdata`. Request inputs are don't-care after that edge.
- Illegal encodings: funct3 ∈ {011,110,111}, or a store with funct3 ∈ {100,101}. These set fault[1].
- Misaligned accesses: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0. These set fault[0]. Evaluate misalignment only when the encoding is legal.
- Any fault: go IDLE→RESP directly and issue no memory transaction. Otherwise go IDLE→MEM.
- MEM:
  - `mem_valid`=1.
  - `mem_addr`/`mem_we`/`mem_wstrb`/`mem_wdata` are held stable until `mem_ready` is sampled high.
  - On a `mem_ready` edge: capture the extended load data and go MEM→RESP.
  - There is no timeout; MEM waits indefinitely.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE. `resp_rdata`/`resp_fault` are valid only while `resp_valid`=1 and are 0 otherwise.
- Store lanes, with o = `addr[1:0]`:
  - SB: `mem_wdata`={4{wdata[7:0]}}, `mem_wstrb`=4'b0001<<o.
  - SH: `mem_wdata`={2{wdata[15:0]}}, `mem_wstrb`=o[1]?1100:0011.
  - SW: `mem_wdata`=wdata, `mem_wstrb`=1111.
- Loads drive `mem_wstrb`=0 and `mem_wdata`=0.
- Load extraction:
  - Byte = `rdata[8o+7:8o]`; halfword = `rdata[16o[1]+15:16o[1]]`.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Reset during MEM or RESP: `mem_valid` and `resp_valid` drop immediately. The pending access is abandoned with no response.

## Timing
- Accepting edge at T0 (normal access):
  - `mem_valid` is high from T0 until the edge where `mem_ready`=1, at Tk (k≥1).
  - `resp_valid` is high in the cycle after Tk.
  - Minimum latency, with `mem_ready` held high: 2 cycles from acceptance to `resp_valid`.
- Accepting edge at T0 (faulted access): `resp_valid` is high in the cycle after T0, giving 1 cycle of latency.
- `req_ready` is low from acceptance through the RESP cycle. The next request can be accepted at the edge ending RESP+1; no back-to-back overlap.
- `req_valid` asserted while `req_ready`=0 is ignored and not queued. The core holds `req_valid` until accepted.
- `mem_ready` outside MEM is ignored.

## Test plan
- SW: addr=0x0000_1008, wdata=0xDEADBEEF, `mem_ready` tied 1.
  - Response: `mem_addr`=0x1008, `mem_wstrb`=1111, `mem_wdata`=0xDEADBEEF.
  - `resp_valid` pulses 2 cycles after acceptance with `resp_fault`=00 and `resp_rdata`=0.
- SB: addr=0x1003, wdata=0x0000_00A5.
  - Response: `mem_wdata`=0xA5A5A5A5, `mem_wstrb`=1000, `mem_addr`=0x1000.
- Loads, with `mem_rdata`=0x80F1_7F82:
  - LB @0x…0 returns 0xFFFF_FF82.
  - LBU @0x…0 returns 0x0000_0082.
  - LH @0x…2 returns 0xFFFF_80F1.
  - LHU @0x…2 returns 0x0000_80F1.
  - LB @0x…1 returns 0x0000_007F.
- LW with `mem_ready` held low for 5 cycles:
  - `mem_valid` and `mem_addr` stay stable and `stall`=1 throughout.
  - `resp_valid` is high exactly one cycle after `mem_ready` rises.
- Faults:
  - LW @0x1002 → `mem_valid` never asserts, `resp_fault`=01, 1-cycle latency.
  - Store with funct3=100 → `resp_fault`=10.
  - funct3=011 → `resp_fault`=10.
- Reset mid-MEM: assert `reset` while `mem_valid`=1.
  - `mem_valid` drops without waiting for a clock edge, no `resp_valid`, and `req_ready`=1 after reset deasserts.

Source files
------------

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between the ALU and data memory
// One transaction per request: IDLE -> MEM -> RESP, or IDLE -> RESP on a fault.
module lsu #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic [1:0]    resp_fault,
  output logic          stall
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    fault_q, fault_d;

  logic          illegal, misaligned;
  logic [1:0]    o;
  logic [7:0]    lbyte;
  logic [15:0]   lhalf;
  logic [31:0]   load_ext;
  logic [3:0]    wstrb;
  logic [31:0]   wdata_lanes;

  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    misaligned = 1'b0;
    if (!illegal) begin
      if (req_funct3[1:0] == 2'b01)      misaligned = req_addr[0];
      else if (req_funct3[1:0] == 2'b10) misaligned = (req_addr[1:0] != 2'b00);
    end
  end

  assign o = addr_q[1:0];

  always_comb begin
    lbyte    = mem_rdata[8*o +: 8];
    lhalf    = o[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{lbyte[7]}}, lbyte};
      3'b001:  load_ext = {{16{lhalf[15]}}, lhalf};
      3'b100:  load_ext = {24'd0, lbyte};
      3'b101:  load_ext = {16'd0, lhalf};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    wstrb       = 4'b1111;
    wdata_lanes = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        wstrb       = 4'b0001 << o;
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wstrb       = o[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = 32'd0;
        fault_d = {illegal, misaligned};
        state_d = (illegal || misaligned) ? RESP : MEM;
      end
      MEM: if (mem_ready) begin
        rdata_d = we_q ? 32'd0 : load_ext;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 2'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Memory and response buses read as zero outside their own state.
  assign req_ready  = (state_q == IDLE);
  assign stall      = ~req_ready;
  assign mem_valid  = (state_q == MEM);
  assign mem_we     = mem_valid & we_q;
  assign mem_addr   = mem_valid ? {addr_q[AW-1:2], 2'b00} : '0;
  assign mem_wstrb  = (mem_valid && we_q) ? wstrb : 4'd0;
  assign mem_wdata  = (mem_valid && we_q) ? wdata_lanes : 32'd0;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_fault = resp_valid ? fault_q : 2'd0;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu
// Reference model works from byte-lane arithmetic on the request fields.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic        stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu #(.AW(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .stall(stall)
  );

  function automatic logic [1:0] m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (f3 == 3 || f3 == 6 || f3 == 7 || (we && f3 >= 4)) return 2'b10;
    size = 1 << (f3 % 4);
    return (a % size != 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int size, base;
    logic [3:0] s;
    size = 1 << (f3 % 4);
    base = (a % 4) / size * size;
    s = 4'd0;
    for (int i = 0; i < 4; i++) if (i >= base && i < base + size) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int size;
    logic [31:0] r;
    size = 1 << (f3 % 4);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int size, base;
    logic [31:0] v;
    logic [7:0]  b;
    logic [15:0] h;
    size = 1 << (f3 % 4);
    base = (a % 4) / size * size;
    v = rd >> (8 * base);
    b = v[7:0];
    h = v[15:0];
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return rd;
    endcase
  endfunction

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits);
    logic [1:0]  ef;
    logic [31:0] er;
    ef = m_fault(we, f3, a);
    er = (we || ef != 0) ? 32'd0 : m_load(f3, a, rd);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    if (ef == 2'b00) begin
      for (int w = 0; w <= waits; w++) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== {a[31:2], 2'b00} || mem_we !== we || stall !== 1'b1 ||
            mem_wstrb !== (we ? m_strb(f3, a) : 4'd0) || mem_wdata !== (we ? m_wdata(f3, wd) : 32'd0) ||
            resp_valid !== 1'b0) begin
          failures++;
          $display("FAIL mem_phase f3=%0d a=%h got v=%b addr=%h we=%b strb=%b wd=%h stall=%b exp addr=%h strb=%b wd=%h",
                   f3, a, mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata, stall,
                   {a[31:2], 2'b00}, we ? m_strb(f3, a) : 4'd0, we ? m_wdata(f3, wd) : 32'd0);
        end
        if (w == waits) begin mem_ready = 1'b1; mem_rdata = rd; end
        else mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_fault !== ef || resp_rdata !== er || mem_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL resp f3=%0d we=%b a=%h got v=%b fault=%b rdata=%h mv=%b rr=%b exp fault=%b rdata=%h",
               f3, we, a, resp_valid, resp_fault, resp_rdata, mem_valid, req_ready, ef, er);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_fault !== 2'd0 || req_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL post_resp got v=%b rdata=%h fault=%b ready=%b exp v=0 rdata=0 fault=0 ready=1",
               resp_valid, resp_rdata, resp_fault, req_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wstrb !== 4'd0 || mem_wdata !== 32'd0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_fault !== 2'd0) begin
      failures++;
      $display("FAIL reset_values got ready=%b stall=%b mv=%b addr=%h strb=%b wd=%h rv=%b rd=%h f=%b exp idle zeros",
               req_ready, stall, mem_valid, mem_addr, mem_wstrb, mem_wdata, resp_valid, resp_rdata, resp_fault);
    end
  endtask

  task automatic test_stores;
    do_op(1'b1, 3'b010, 32'h0000_1008, 32'hDEADBEEF, 32'h0, 0);
    do_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
    do_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 1);
    do_op(1'b1, 3'b000, 32'h0000_2001, 32'h0000_003C, 32'h0, 0);
  endtask

  task automatic test_loads;
    do_op(1'b0, 3'b000, 32'h0000_3000, 32'h0, 32'h80F1_7F82, 0);
    do_op(1'b0, 3'b100, 32'h0000_3000, 32'h0, 32'h80F1_7F82, 0);
    do_op(1'b0, 3'b001, 32'h0000_3002, 32'h0, 32'h80F1_7F82, 0);
    do_op(1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'h80F1_7F82, 0);
    do_op(1'b0, 3'b000, 32'h0000_3001, 32'h0, 32'h80F1_7F82, 0);
    do_op(1'b0, 3'b000, 32'h0000_3003, 32'h0, 32'h80F1_7F82, 0);
  endtask

  task automatic test_wait_states;
    do_op(1'b0, 3'b010, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 5);
  endtask

  task automatic test_faults;
    do_op(1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0);
    do_op(1'b1, 3'b100, 32'h0000_1000, 32'h1111_2222, 32'h0, 0);
    do_op(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0);
    do_op(1'b1, 3'b001, 32'h0000_1003, 32'h5555_AAAA, 32'h0, 0);
    do_op(1'b0, 3'b111, 32'h0000_1001, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset_mid_mem;
    int rv_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_5000;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1) begin failures++; $display("FAIL mid_mem_enter got mv=%b exp=1", mem_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL async_drop got mv=%b exp=0", mem_valid); end
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid) rv_seen++;
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_valid) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_abandon got resp_or_mem_cycles=%0d ready=%b exp 0 and 1", rv_seen, req_ready);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b110; req_addr = 32'h0000_6000;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_first got rv=%b rr=%b exp 1 0", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_gap got rv=%b rr=%b exp 0 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_fault !== 2'b10) begin
      failures++; $display("FAIL b2b_second got rv=%b f=%b exp 1 10", resp_valid, resp_fault);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_end got mv=%b rr=%b exp 0 1", mem_valid, req_ready);
    end
  endtask

  task automatic test_random;
    logic [2:0] f3;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom);
      do_op(1'($urandom), f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    test_reset;
    test_stores;
    test_loads;
    test_wait_states;
    test_faults;
    test_reset_mid_mem;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
